// File: rtl/mult_div_unit_if.sv
// Handshake/operand bundle between the control path and mult_div_unit.
// The unit side (slave) consumes start pulses and operands and drives status and HI/LO.
interface mult_div_unit_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start_mult, start_div, a_in, b_in,
        input  busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start_mult, start_div, a_in, b_in,
        output busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring, magnitudes) into HI/LO, 32 steps each.
// The divider is built only when MULTDIV_DIV_EN is defined; otherwise start_div is ignored.
module mult_div_unit (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [64:0] work;
    logic [31:0] operand;
    logic [32:0] booth_sum;
    logic [64:0] booth_next;

    always_comb begin
        booth_sum = {work[64], work[64:33]};
        case (work[1:0])
            2'b01:   booth_sum = {work[64], work[64:33]} + {operand[31], operand};
            2'b10:   booth_sum = {work[64], work[64:33]} - {operand[31], operand};
            default: booth_sum = {work[64], work[64:33]};
        endcase
        // A is widened by one bit so a 0x80000000 multiplicand cannot overflow before the shift
        booth_next = {booth_sum, work[32:1]};
    end

`ifdef MULTDIV_DIV_EN
    logic        is_div;
    logic        zero_div;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [64:0] div_next;

    // Divide layout: work[63:32] = partial remainder, work[31:0] = dividend shifting into quotient
    always_comb begin
        abs_a     = bus.a_in[31] ? -bus.a_in : bus.a_in;
        abs_b     = bus.b_in[31] ? -bus.b_in : bus.b_in;
        div_shift = {work[63:32], work[31]};
        div_trial = div_shift - {1'b0, operand};
        if (div_trial[32]) begin
            div_next = {1'b0, div_shift[31:0], work[30:0], 1'b0};
        end else begin
            div_next = {1'b0, div_trial[31:0], work[30:0], 1'b1};
        end
        quo_fix = neg_quo ? -work[31:0] : work[31:0];
        rem_fix = neg_rem ? -work[63:32] : work[63:32];
    end
`else
    logic unused_start_div;
    assign unused_start_div = bus.start_div;
    assign bus.div_by_zero  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            work        <= '0;
            operand     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.hi_out  <= '0;
            bus.lo_out  <= '0;
`ifdef MULTDIV_DIV_EN
            bus.div_by_zero <= 1'b0;
            is_div          <= 1'b0;
            zero_div        <= 1'b0;
            neg_quo         <= 1'b0;
            neg_rem         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
`ifdef MULTDIV_DIV_EN
                    bus.div_by_zero <= 1'b0;
`endif
                    // The done cycle is spent here with busy still high; starts wait one more cycle
                    if (!bus.busy) begin
                        if (bus.start_mult) begin
                            state    <= MULT;
                            bus.busy <= 1'b1;
                            count    <= '0;
                            operand  <= bus.a_in;
                            work     <= {32'b0, bus.b_in, 1'b0};
`ifdef MULTDIV_DIV_EN
                            is_div   <= 1'b0;
                            zero_div <= 1'b0;
`endif
                        end
`ifdef MULTDIV_DIV_EN
                        else if (bus.start_div) begin
                            state    <= (bus.b_in == '0) ? FINISH : DIV;
                            bus.busy <= 1'b1;
                            count    <= '0;
                            operand  <= abs_b;
                            work     <= {33'b0, abs_a};
                            is_div   <= 1'b1;
                            zero_div <= (bus.b_in == '0);
                            neg_quo  <= bus.a_in[31] ^ bus.b_in[31];
                            neg_rem  <= bus.a_in[31];
                        end
`endif
                    end
                end
                MULT: begin
                    work  <= booth_next;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= FINISH;
                    end
                end
`ifdef MULTDIV_DIV_EN
                DIV: begin
                    work  <= div_next;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= FINISH;
                    end
                end
`endif
                FINISH: begin
                    state    <= IDLE;
                    bus.done <= 1'b1;
                    count    <= '0;
`ifdef MULTDIV_DIV_EN
                    if (zero_div) begin
                        bus.div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        bus.hi_out <= rem_fix;
                        bus.lo_out <= quo_fix;
                    end else begin
                        bus.hi_out <= work[64:33];
                        bus.lo_out <= work[32:1];
                    end
`else
                    bus.hi_out <= work[64:33];
                    bus.lo_out <= work[32:1];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, hand-written control/reset sequences and
// random operations against a plain-arithmetic model; adapts to MULTDIV_DIV_EN.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic d, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, input logic dbz);
        vec_t v;
        v.m = m; v.d = d; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Start one operation from a negedge and watch 40 cycles after the accepting edge (E0).
    // poke_div/poke_mult: edge number at which an extra start pulse is sampled (0 = none).
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int poke_div, input int poke_mult,
                         output logic [31:0] got_hi, output logic [31:0] got_lo,
                         output logic got_dbz);
        logic [63:0] prod;
        longint      sa, sb;
        logic [31:0] old_hi, old_lo;
        int          exp_lat, exp_busy, lat, busy_n, done_n;
        logic        exp_dbz, held;
`ifdef MULTDIV_DIV_EN
        longint      q, r;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        old_hi = exp_hi;
        old_lo = exp_lo;
        exp_dbz = 1'b0;
        exp_lat = 33;
        exp_busy = 34;
        if (m) begin
            prod = sa * sb;
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
        end
`ifdef MULTDIV_DIV_EN
        else if (d && sb == 0) begin
            exp_dbz = 1'b1;
            exp_lat = 1;
            exp_busy = 2;
        end else if (d) begin
            q = sa / sb;
            r = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
`endif
        else begin
            exp_lat = -1;
            exp_busy = 0;
        end

        got_hi = old_hi; got_lo = old_lo; got_dbz = 1'b0;
        lat = -1; busy_n = 0; done_n = 0; held = 1'b1;
        bus.start_mult = m; bus.start_div = d; bus.a_in = a; bus.b_in = b;
        @(negedge clock);
        bus.start_mult = 1'b0; bus.start_div = 1'b0;
        bus.a_in = $urandom; bus.b_in = $urandom;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (lat < 0) begin
                    lat = c;
                    got_hi = bus.hi_out;
                    got_lo = bus.lo_out;
                    got_dbz = bus.div_by_zero;
                end
            end else if (bus.div_by_zero) begin
                got_dbz = 1'b1;
            end
            if (done_n == 0 && (bus.hi_out !== old_hi || bus.lo_out !== old_lo)) held = 1'b0;
            bus.start_div  = (c == poke_div - 1);
            bus.start_mult = (c == poke_mult - 1);
            if (bus.start_div || bus.start_mult) begin
                bus.a_in = $urandom; bus.b_in = $urandom;
            end
            @(negedge clock);
        end
        bus.start_div = 1'b0; bus.start_mult = 1'b0;
        chk("latency",     64'(lat),     64'(exp_lat));
        chk("done_pulses", 64'(done_n),  64'(exp_lat < 0 ? 0 : 1));
        chk("busy_cycles", 64'(busy_n),  64'(exp_busy));
        chk("hilo_hold",   64'(held),    64'(1'b1));
        chk("hi",          64'(got_hi),  64'(exp_hi));
        chk("lo",          64'(got_lo),  64'(exp_lo));
        chk("div_by_zero", 64'(got_dbz), 64'(exp_dbz));
        chk("hilo_final",  {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
    endtask

    vec_t        vecs[$];
    logic [31:0] gh, gl;
    logic        gd;
    int          done_n;

    initial begin
        reset = 1'b0;
        bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a_in = '0; bus.b_in = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 64'(bus.busy), 64'(1'b0));
        chk("rst_done", 64'(bus.done), 64'(1'b0));
        chk("rst_dbz",  64'(bus.div_by_zero), 64'(1'b0));
        chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'h0);
        reset = 1'b1;
        @(negedge clock);

        vecs.push_back(mk(1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0));
        vecs.push_back(mk(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0));
        vecs.push_back(mk(1, 1, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 0));
`ifdef MULTDIV_DIV_EN
        vecs.push_back(mk(0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0));
        vecs.push_back(mk(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0));
        vecs.push_back(mk(1, 0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 0));
        vecs.push_back(mk(0, 1, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 1));
`else
        vecs.push_back(mk(1, 0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 0));
        vecs.push_back(mk(0, 1, 32'd5,        32'd0,        32'h11111111, 32'h22222222, 0));
        vecs.push_back(mk(0, 1, 32'hFFFFFFF9, 32'd2,        32'h11111111, 32'h22222222, 0));
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 0, 0, gh, gl, gd);
            chk("vec_hi",  64'(gh), 64'(vecs[i].hi));
            chk("vec_lo",  64'(gl), 64'(vecs[i].lo));
            chk("vec_dbz", 64'(gd), 64'(vecs[i].dbz));
        end

        // start_div at E5 of a MULT, then start_mult during the done cycle: both ignored
        do_op(1, 0, 32'h12345678, 32'hFEDCBA98, 5, 34, gh, gl, gd);

        // reset at E10 of a MULT
        done_n = 0;
        bus.start_mult = 1'b1; bus.a_in = 32'd1234; bus.b_in = 32'd5678;
        @(negedge clock);
        bus.start_mult = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_n++;
            if (c == 9) begin
                chk("pre_rst_busy", 64'(bus.busy), 64'(1'b1));
                reset = 1'b0;
            end
            if (c == 10) begin
                chk("abort_busy", 64'(bus.busy), 64'(1'b0));
                chk("abort_hilo", {bus.hi_out, bus.lo_out}, 64'h0);
                reset = 1'b1;
            end
            @(negedge clock);
        end
        chk("abort_no_done", 64'(done_n), 64'(0));
        exp_hi = '0;
        exp_lo = '0;

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            logic        rm, rd;
            case ($urandom_range(0, 4))
                0:       ra = 32'h80000000;
                1:       ra = $urandom_range(0, 15);
                2:       ra = 32'hFFFFFFFF - $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            rm = 1'($urandom_range(0, 1));
            rd = !rm || ($urandom_range(0, 3) == 0);
            do_op(rm, rd, ra, rb, 0, 0, gh, gl, gd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
